// File: rtl/progmem_arbiter.sv
// -----------------------------------------------------------------------------
// progmem_arbiter
//   Shares one single-port, registered-read program memory between N_CORES
//   fetching cores. One core is granted per cycle. The current owner keeps the
//   memory for up to MAX_BURST consecutive fetches while another core waits, so
//   sequential fetches stay back-to-back. Otherwise the memory goes round-robin
//   from rr_ptr. Cores that request but are not granted are stalled.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   core_req   : per-core fetch request
//   core_addr  : per-core byte address, core i at [i*INST_ADDR_W +: INST_ADDR_W]
//   core_stall : 1 = core must hold its PC/pipeline (drives ~en)
//   core_valid : 1-cycle pulse, core_data holds core i's instruction
//   core_data  : broadcast read data (mem_data passed through)
//   mem_re     : memory read enable
//   mem_addr   : word-aligned byte address to memory
//   mem_data   : memory read data, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module progmem_arbiter #(
   parameter int N_CORES     = 4,
   parameter int INST_ADDR_W = 32,
   parameter int INST_W      = 32,
   parameter int MAX_BURST   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_CORES-1:0]             core_req,
   input  logic [N_CORES*INST_ADDR_W-1:0] core_addr,
   output logic [N_CORES-1:0]             core_stall,
   output logic [N_CORES-1:0]             core_valid,
   output logic [INST_W-1:0]              core_data,
   output logic                           mem_re,
   output logic [INST_ADDR_W-1:0]         mem_addr,
   input  logic [INST_W-1:0]              mem_data
);

   localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CORES - 1);
   localparam logic [INST_ADDR_W-1:0] WORD_MASK = {{(INST_ADDR_W-2){1'b1}}, 2'b00};

   // State
   logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
   logic               owner_vld_q, owner_vld_d;
   logic [IDX_W-1:0]   owner_q,     owner_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic [N_CORES-1:0] valid_q,     valid_d;

   // Grant path
   logic               others_req_s;
   logic               keep_s;
   logic               found_s;
   logic [IDX_W-1:0]   srch_idx_s;
   logic               any_grant_s;
   logic [IDX_W-1:0]   gidx_s;
   logic [N_CORES-1:0] grant_s;
   logic [INST_ADDR_W-1:0] sel_addr_s;

   // Grant decision: keep the burst owner if allowed, otherwise round-robin search.
   always_comb begin
      others_req_s = 1'b0;
      keep_s       = 1'b0;
      found_s      = 1'b0;
      srch_idx_s   = '0;
      any_grant_s  = 1'b0;
      gidx_s       = '0;
      grant_s      = '0;

      // Any requester other than the current owner (everyone counts when there is no owner).
      for (int i = 0; i < N_CORES; i++) begin
         others_req_s = others_req_s |
                        (core_req[i] & ~(owner_vld_q & (owner_q == IDX_W'(i))));
      end

      // Owner keeps the memory under its burst budget, or indefinitely when nobody else waits.
      keep_s = owner_vld_q & core_req[owner_q] &
               ((burst_cnt_q < CNT_MAX) | ~others_req_s);

      // First requester at rr_ptr, rr_ptr+1, ... modulo N_CORES.
      for (int k = 0; k < N_CORES; k++) begin
         int idx;
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_CORES) begin
            idx = idx - N_CORES;
         end else begin
            idx = idx;
         end
         if (!found_s && core_req[IDX_W'(idx)]) begin
            found_s    = 1'b1;
            srch_idx_s = IDX_W'(idx);
         end else begin
            found_s    = found_s;
         end
      end

      if (keep_s) begin
         any_grant_s = 1'b1;
         gidx_s      = owner_q;
      end else begin
         any_grant_s = found_s;
         gidx_s      = srch_idx_s;
      end

      // While reset is held nothing is granted, so every requester stays stalled.
      if (rst) begin
         any_grant_s = 1'b0;
      end else begin
         any_grant_s = any_grant_s;
      end

      if (any_grant_s) begin
         grant_s = {{(N_CORES-1){1'b0}}, 1'b1} << gidx_s;
      end else begin
         grant_s = '0;
      end
   end

   // Memory address mux for the granted core.
   always_comb begin
      sel_addr_s = '0;
      for (int i = 0; i < N_CORES; i++) begin
         if (gidx_s == IDX_W'(i)) begin
            sel_addr_s = core_addr[i*INST_ADDR_W +: INST_ADDR_W];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
   end

   assign mem_re     = any_grant_s;
   assign mem_addr   = sel_addr_s & WORD_MASK;
   assign core_stall = core_req & ~grant_s;
   assign core_valid = valid_q;
   assign core_data  = mem_data;

   // Next-state for owner tracking, burst counter and round-robin pointer.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      owner_vld_d = owner_vld_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      valid_d     = grant_s;

      if (any_grant_s) begin
         if (!owner_vld_q || (gidx_s != owner_q)) begin
            owner_vld_d = 1'b1;
            owner_d     = gidx_s;
            burst_cnt_d = CNT_ONE;
            rr_ptr_d    = (gidx_s == LAST_IDX) ? '0 : (gidx_s + IDX_W'(1));
         end else begin
            // Saturate so a lone requester never wraps back into a fresh budget.
            burst_cnt_d = (burst_cnt_q < CNT_MAX) ? (burst_cnt_q + CNT_ONE) : burst_cnt_q;
         end
      end else begin
         owner_vld_d = 1'b0;
         burst_cnt_d = '0;
      end
   end

   // State registers with synchronous reset; clearing valid_q drops any read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         owner_vld_q <= 1'b0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         valid_q     <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         owner_vld_q <= owner_vld_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         valid_q     <= valid_d;
      end
   end

endmodule

// File: tb/tb_progmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_progmem_arbiter
//   Directed, table-driven bench for progmem_arbiter (4 cores, MAX_BURST=4).
//   Each table row is one clock cycle: inputs plus the hand-computed granted
//   core (4 = none) and the expected core_valid vector. A registered-read
//   memory model supplies mem_data. A hand-written sequence then measures the
//   wait of one core against three competitors.
// -----------------------------------------------------------------------------
module tb_progmem_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            rst;
   logic [N-1:0]    core_req;
   logic [N*AW-1:0] core_addr;
   logic [N-1:0]    core_stall;
   logic [N-1:0]    core_valid;
   logic [DW-1:0]   core_data;
   logic            mem_re;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_data;

   progmem_arbiter #(
      .N_CORES    (N),
      .INST_ADDR_W(AW),
      .INST_W     (DW),
      .MAX_BURST  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .core_req  (core_req),
      .core_addr (core_addr),
      .core_stall(core_stall),
      .core_valid(core_valid),
      .core_data (core_data),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read program memory: word w holds 0xC0DE0000 + w.
   logic [DW-1:0] progmem [256];
   initial begin
      for (int w = 0; w < 256; w++) progmem[w] = 32'hC0DE_0000 + DW'(w);
   end
   always @(posedge clk) begin
      if (mem_re) mem_data <= progmem[mem_addr[9:2]];
   end

   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      logic [AW-1:0] a2;    // core2 address (other cores use fixed unaligned addresses)
      int           g;      // expected granted core, 4 = none
      logic [N-1:0] v;      // expected core_valid
   } vec_t;

   vec_t vq[$];
   int checks   = 0;
   int failures = 0;

   function automatic logic [AW-1:0] addr_of(input int g, input logic [AW-1:0] a2);
      case (g)
         0:       return 32'h0000_0003;
         1:       return 32'h0000_0103;
         2:       return a2;
         3:       return 32'h0000_0303;
         default: return 32'h0000_0000;
      endcase
   endfunction

   task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%08h expected=0x%08h", name, n, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [N-1:0] q, input logic [AW-1:0] a, input int g, input logic [N-1:0] v);
      vq.push_back('{rst: r, req: q, a2: a, g: g, v: v});
   endtask

   task automatic add_n(input int cnt, input logic r, input logic [N-1:0] q, input logic [AW-1:0] a, input int g, input logic [N-1:0] v);
      for (int i = 0; i < cnt; i++) add(r, q, a, g, v);
   endtask

   initial begin
      logic [AW-1:0] prev_addr;
      logic [N-1:0]  onehot;
      logic [AW-1:0] exp_addr;
      int            waited;
      logic          granted;

      rst       = 1'b1;
      core_req  = '0;
      core_addr = '0;
      prev_addr = '0;

      // Reset held with all requesting; then the full round-robin rotation.
      add_n(2, 1'b1, 4'b1111, 32'h203, 4, 4'b0000);
      add  (   1'b0, 4'b1111, 32'h203, 0, 4'b0000);
      add_n(3, 1'b0, 4'b1111, 32'h203, 0, 4'b0001);
      add  (   1'b0, 4'b1111, 32'h203, 1, 4'b0001);
      add_n(3, 1'b0, 4'b1111, 32'h203, 1, 4'b0010);
      add  (   1'b0, 4'b1111, 32'h203, 2, 4'b0010);
      add_n(3, 1'b0, 4'b1111, 32'h203, 2, 4'b0100);
      add  (   1'b0, 4'b1111, 32'h203, 3, 4'b0100);
      add_n(3, 1'b0, 4'b1111, 32'h203, 3, 4'b1000);
      add  (   1'b0, 4'b1111, 32'h203, 0, 4'b1000);   // rr_ptr wrapped 3 -> 0
      // Core1 becomes owner (rr_ptr=2), then reset: owner/rr_ptr cleared, core0 wins.
      add  (   1'b0, 4'b0010, 32'h203, 1, 4'b0001);
      add  (   1'b1, 4'b0011, 32'h203, 4, 4'b0010);
      add  (   1'b0, 4'b0011, 32'h203, 0, 4'b0000);
      // Sole requester core2, sequential addresses beyond MAX_BURST.
      add  (   1'b0, 4'b0100, 32'h040, 2, 4'b0001);
      add  (   1'b0, 4'b0100, 32'h044, 2, 4'b0100);
      add  (   1'b0, 4'b0100, 32'h048, 2, 4'b0100);
      add  (   1'b0, 4'b0100, 32'h04C, 2, 4'b0100);
      add  (   1'b0, 4'b0100, 32'h050, 2, 4'b0100);
      add  (   1'b0, 4'b0100, 32'h054, 2, 4'b0100);
      add  (   1'b0, 4'b0000, 32'h054, 4, 4'b0100);
      add  (   1'b0, 4'b0000, 32'h054, 4, 4'b0000);
      // Core1 owner at burst 2 with rr_ptr=2 drops while core3 waits -> core3, rr_ptr=0.
      add  (   1'b0, 4'b0010, 32'h203, 1, 4'b0000);
      add  (   1'b0, 4'b1010, 32'h203, 1, 4'b0010);
      add  (   1'b0, 4'b1000, 32'h203, 3, 4'b0010);
      add  (   1'b0, 4'b0011, 32'h203, 0, 4'b1000);
      add  (   1'b0, 4'b0011, 32'h203, 0, 4'b0001);
      add  (   1'b0, 4'b0000, 32'h203, 4, 4'b0001);
      add  (   1'b0, 4'b0000, 32'h203, 4, 4'b0000);

      for (int n = 0; n < vq.size(); n++) begin
         @(negedge clk);
         rst       = vq[n].rst;
         core_req  = vq[n].req;
         core_addr = {32'h0000_0303, vq[n].a2, 32'h0000_0103, 32'h0000_0003};
         #1;
         onehot   = (vq[n].g < N) ? (4'b0001 << vq[n].g) : 4'b0000;
         exp_addr = addr_of(vq[n].g, vq[n].a2) & 32'hFFFF_FFFC;
         chk("mem_re", n, 32'(mem_re), 32'(vq[n].g < N));
         if (vq[n].g < N) chk("mem_addr", n, mem_addr, exp_addr);
         chk("core_stall", n, 32'(core_stall), 32'(vq[n].req & ~onehot));
         chk("core_valid", n, 32'(core_valid), 32'(vq[n].v));
         if (vq[n].v != 4'b0000) chk("core_data", n, core_data, 32'hC0DE_0000 + 32'(prev_addr[9:2]));
         if (vq[n].g < N) prev_addr = exp_addr;
      end

      // Hand sequence: rr_ptr=1, no owner; all request -> core1 bursts 4, then core2.
      waited  = 0;
      granted = 1'b0;
      while (!granted && waited < 20) begin
         @(negedge clk);
         rst       = 1'b0;
         core_req  = 4'b1111;
         core_addr = {32'h0000_0303, 32'h0000_0203, 32'h0000_0103, 32'h0000_0003};
         #1;
         if (core_stall[2]) begin
            waited++;
         end else begin
            granted = 1'b1;
            chk("wait_grant_addr", waited, mem_addr, 32'h0000_0200);
         end
      end
      chk("wait_cycles", waited, 32'(waited), 32'd4);
      chk("wait_bound", waited, 32'(waited <= (N - 1) * 4), 32'd1);

      @(negedge clk);
      core_req = '0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
